// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared types and helpers for the next-PC sequencer.
//   state_e : RUN / HALT / FAULT sequencer state (2-bit encoding)
//   sel_e   : next-PC source select
//   PC_INC  : byte increment between sequential instructions
//   align() : clears bits [1:0] so that every target is word-aligned
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_RAS  = 3'd4
    } sel_e;

    localparam int PC_INC = 4;

    // Works on a generous 32-bit container so callers of any PC width
    // can cast in and out of it.
    function automatic logic [31:0] align(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack
// Return-address stack: a small LIFO with a registered stack pointer.
//   clk, reset : clock, asynchronous active-high reset (empties the stack)
//   push, din  : push din when not full
//   pop        : discard the top entry when not empty
//   top        : current top-of-stack entry (combinational read)
//   depth      : number of valid entries
//   full/empty : stack occupancy flags
module ras_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              din,
    output logic [PC_W-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(RAS_DEPTH);

    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [AW:0]     sp;
    logic [AW:0]     sp_minus_one;

    // sp counts valid entries, so the top entry lives one slot below it.
    // When empty the index wraps to the last slot, which holds a known
    // value because the array is cleared on reset.
    assign sp_minus_one = sp - (AW+1)'(1);
    assign top          = mem[sp_minus_one[AW-1:0]];
    assign depth        = sp;
    assign full         = (sp == (AW+1)'(RAS_DEPTH));
    assign empty        = (sp == '0);

    // Storage and pointer. Push and pop are mutually exclusive at the
    // sequencer, but push still wins here so the stack is well defined
    // on its own; overflow/underflow requests are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[sp[AW-1:0]] <= din;
            sp              <= sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp_minus_one;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller for the single-cycle core. Chooses between sequential,
// branch, jump, call and return targets, holds the PC on stall/halt, and
// owns the return-address stack plus a RUN/HALT/FAULT state machine.
//   clk, reset     : clock, asynchronous active-high reset
//   pc_cur         : current program counter value
//   stall, halt    : hold PC this cycle / enter HALT
//   resume         : leave HALT
//   branch_taken, branch_target : taken conditional branch and destination
//   jump, call, jump_target     : unconditional jump / jump-and-link
//   ret            : return through the RAS
//   pc_next        : next PC for the program counter (combinational)
//   flush          : a redirect is taken this cycle (combinational)
//   halted, fault  : state decodes (registered; fault is sticky)
//   ras_depth      : number of valid RAS entries (registered)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 7,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PC_W-1:0]             pc_cur,
    input  logic                        stall,
    input  logic                        halt,
    input  logic                        resume,
    input  logic                        branch_taken,
    input  logic [PC_W-1:0]             branch_target,
    input  logic                        jump,
    input  logic                        call,
    input  logic [PC_W-1:0]             jump_target,
    input  logic                        ret,
    output logic [PC_W-1:0]             pc_next,
    output logic                        flush,
    output logic                        halted,
    output logic                        fault,
    output logic [$clog2(RAS_DEPTH):0]  ras_depth
);

    state_e          state, state_next;
    sel_e            sel;
    logic            push, pop;
    logic            ras_full, ras_empty;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] pc_al, seq, br_al, jt_al, ras_al;

    assign pc_al  = PC_W'(align(32'(pc_cur)));
    assign br_al  = PC_W'(align(32'(branch_target)));
    assign jt_al  = PC_W'(align(32'(jump_target)));
    assign ras_al = PC_W'(align(32'(ras_top)));
    // Wraps naturally at 2^PC_W.
    assign seq    = pc_al + PC_W'(PC_INC);

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (seq),
        .top   (ras_top),
        .depth (ras_depth),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, source select and RAS control. The RUN branch encodes
    // the priority halt > stall > ret > call > jump > branch > sequential.
    // Illegal RAS use (pop when empty, push when full) holds the PC and
    // traps into FAULT instead of redirecting. Nothing is requested while
    // reset is high so flush stays quiet during reset.
    always_comb begin
        state_next = state;
        sel        = SEL_HOLD;
        flush      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state_next = HALT;
                    end else if (stall) begin
                        sel = SEL_HOLD;
                    end else if (ret) begin
                        if (!ras_empty) begin
                            sel   = SEL_RAS;
                            pop   = 1'b1;
                            flush = 1'b1;
                        end else begin
                            state_next = FAULT;
                        end
                    end else if (call) begin
                        if (!ras_full) begin
                            sel   = SEL_JMP;
                            push  = 1'b1;
                            flush = 1'b1;
                        end else begin
                            state_next = FAULT;
                        end
                    end else if (jump) begin
                        sel   = SEL_JMP;
                        flush = 1'b1;
                    end else if (branch_taken) begin
                        sel   = SEL_BR;
                        flush = 1'b1;
                    end else begin
                        sel = SEL_SEQ;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_next = RUN;
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = FAULT;
                end
            endcase
        end
    end

    // Next-PC mux; reset overrides every source.
    always_comb begin
        pc_next = pc_al;
        if (reset) begin
            pc_next = RESET_PC;
        end else begin
            case (sel)
                SEL_SEQ:  pc_next = seq;
                SEL_BR:   pc_next = br_al;
                SEL_JMP:  pc_next = jt_al;
                SEL_RAS:  pc_next = ras_al;
                default:  pc_next = pc_al;
            endcase
        end
    end

    assign halted = (state == HALT);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer: sequential wrap, redirect priority,
// call/return nesting, RAS overflow/underflow, stall/halt/resume and
// asynchronous reset in the middle of operation.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] pc_cur;
    logic       stall, halt, resume, branch_taken, jump, call, ret;
    logic [6:0] branch_target, jump_target;
    logic [6:0] pc_next;
    logic       flush, halted, fault;
    logic [2:0] ras_depth;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    pc_sequencer #(
        .PC_W      (7),
        .RAS_DEPTH (4),
        .RESET_PC  (7'd0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .stall         (stall),
        .halt          (halt),
        .resume        (resume),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .pc_next       (pc_next),
        .flush         (flush),
        .halted        (halted),
        .fault         (fault),
        .ras_depth     (ras_depth)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Argument order: pc, stall, halt, resume, branch, branch_target,
    // jump, call, jump_target, ret. Settles 1 time unit before returning.
    task automatic applyStimulus(input logic [6:0] pc, input logic st, input logic hl,
                                 input logic rs, input logic br, input logic [6:0] brt,
                                 input logic jp, input logic cl, input logic [6:0] jt,
                                 input logic rt);
        pc_cur        = pc;
        stall         = st;
        halt          = hl;
        resume        = rs;
        branch_taken  = br;
        branch_target = brt;
        jump          = jp;
        call          = cl;
        jump_target   = jt;
        ret           = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkComb(input string tag, input logic [6:0] exp_pc, input logic exp_flush);
        checkOutput({tag, "_pc"}, 32'(pc_next), 32'(exp_pc));
        checkOutput({tag, "_flush"}, 32'(flush), 32'(exp_flush));
    endtask

    task automatic checkRegs(input string tag, input logic exp_halted, input logic exp_fault,
                             input logic [2:0] exp_depth);
        checkOutput({tag, "_halted"}, 32'(halted), 32'(exp_halted));
        checkOutput({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        checkOutput({tag, "_depth"}, 32'(ras_depth), 32'(exp_depth));
    endtask

    initial begin
        // Reset state, including a redirect request that must be ignored
        reset = 1'b1;
        applyStimulus(7'd0, 0, 0, 0, 0, 7'd0, 0, 0, 7'd0, 0);
        checkComb("reset", 7'd0, 1'b0);
        checkRegs("reset", 1'b0, 1'b0, 3'd0);
        applyStimulus(7'd40, 0, 0, 0, 1, 7'd52, 0, 0, 7'd0, 0);
        checkComb("reset_hold", 7'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Sequential run with wrap from 124 to 0
        $display("[TB] sequential run");
        for (int i = 0; i < 34; i++) begin
            applyStimulus(7'((4 * i) % 128), 0, 0, 0, 0, 7'd0, 0, 0, 7'd0, 0);
            checkComb($sformatf("seq%0d", i), 7'((4 * i + 4) % 128), 1'b0);
            tick();
        end

        // Redirect priority
        $display("[TB] branch/jump priority");
        applyStimulus(7'd20, 0, 0, 0, 1, 7'd50, 0, 0, 7'd0, 0);
        checkComb("branch", 7'd48, 1'b1);
        applyStimulus(7'd20, 0, 0, 0, 1, 7'd50, 1, 0, 7'd100, 0);
        checkComb("jump_over_branch", 7'd100, 1'b1);
        applyStimulus(7'd20, 0, 0, 0, 0, 7'd0, 1, 0, 7'd103, 0);
        checkComb("jump_align", 7'd100, 1'b1);
        tick();
        checkRegs("after_jump", 1'b0, 1'b0, 3'd0);

        // Call/return nesting; call+ret together lets ret win
        $display("[TB] call/return nesting");
        applyStimulus(7'd8, 0, 0, 0, 1, 7'd60, 0, 1, 7'd40, 0);
        checkComb("call1", 7'd40, 1'b1);
        tick();
        checkRegs("call1", 1'b0, 1'b0, 3'd1);
        applyStimulus(7'd44, 0, 0, 0, 0, 7'd0, 0, 1, 7'd80, 0);
        checkComb("call2", 7'd80, 1'b1);
        tick();
        checkRegs("call2", 1'b0, 1'b0, 3'd2);
        applyStimulus(7'd84, 0, 0, 0, 0, 7'd0, 0, 1, 7'd100, 1);
        checkComb("ret1", 7'd48, 1'b1);
        tick();
        checkRegs("ret1", 1'b0, 1'b0, 3'd1);
        applyStimulus(7'd52, 0, 0, 0, 0, 7'd0, 0, 0, 7'd0, 1);
        checkComb("ret2", 7'd12, 1'b1);
        tick();
        checkRegs("ret2", 1'b0, 1'b0, 3'd0);

        // RAS overflow
        $display("[TB] RAS overflow");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(7'(20 * i), 0, 0, 0, 0, 7'd0, 0, 1, 7'(20 * i + 20), 0);
            checkComb($sformatf("fill%0d", i), 7'(20 * i + 20), 1'b1);
            tick();
        end
        checkRegs("full", 1'b0, 1'b0, 3'd4);
        applyStimulus(7'd80, 0, 0, 0, 0, 7'd0, 0, 1, 7'd100, 0);
        checkComb("overflow", 7'd80, 1'b0);
        tick();
        checkRegs("overflow", 1'b0, 1'b1, 3'd4);
        applyStimulus(7'd80, 0, 0, 1, 1, 7'd8, 0, 0, 7'd0, 1);
        checkComb("fault_hold", 7'd80, 1'b0);
        tick();
        tick();
        checkRegs("fault_sticky", 1'b0, 1'b1, 3'd4);
        reset = 1'b1;
        #1;
        checkRegs("fault_reset", 1'b0, 1'b0, 3'd0);
        tick();
        reset = 1'b0;

        // RAS underflow
        $display("[TB] RAS underflow");
        applyStimulus(7'd24, 0, 0, 0, 0, 7'd0, 0, 0, 7'd0, 1);
        checkComb("underflow", 7'd24, 1'b0);
        tick();
        checkRegs("underflow", 1'b0, 1'b1, 3'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Stall, halt and resume
        $display("[TB] stall/halt/resume");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(7'd16, 1, 0, 0, 1, 7'd60, 0, 0, 7'd0, 0);
            checkComb($sformatf("stall%0d", i), 7'd16, 1'b0);
            tick();
        end
        checkRegs("stall", 1'b0, 1'b0, 3'd0);
        applyStimulus(7'd16, 1, 1, 0, 1, 7'd60, 0, 0, 7'd0, 0);
        checkComb("halt", 7'd16, 1'b0);
        tick();
        checkRegs("halt", 1'b1, 1'b0, 3'd0);
        applyStimulus(7'd16, 0, 0, 0, 1, 7'd60, 1, 1, 7'd100, 0);
        checkComb("halt_ignore", 7'd16, 1'b0);
        tick();
        checkRegs("halt_ignore", 1'b1, 1'b0, 3'd0);
        applyStimulus(7'd16, 0, 0, 1, 0, 7'd0, 0, 0, 7'd0, 0);
        checkComb("resume", 7'd16, 1'b0);
        tick();
        checkRegs("resume", 1'b0, 1'b0, 3'd0);
        applyStimulus(7'd16, 0, 0, 0, 0, 7'd0, 0, 0, 7'd0, 0);
        checkComb("after_resume", 7'd20, 1'b0);
        tick();

        // Asynchronous reset mid-operation
        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(7'(4 + 20 * i), 0, 0, 0, 0, 7'd0, 0, 1, 7'(20 + 20 * i), 0);
            tick();
        end
        applyStimulus(7'd60, 0, 1, 0, 0, 7'd0, 0, 0, 7'd0, 0);
        tick();
        checkRegs("pre_reset", 1'b1, 1'b0, 3'd3);
        #3;
        reset = 1'b1;
        #1;
        checkComb("async_reset", 7'd0, 1'b0);
        checkRegs("async_reset", 1'b0, 1'b0, 3'd0);
        tick();
        reset = 1'b0;
        applyStimulus(7'd28, 0, 0, 0, 0, 7'd0, 0, 0, 7'd0, 1);
        checkComb("post_reset_ret", 7'd28, 1'b0);
        tick();
        checkRegs("post_reset_ret", 1'b0, 1'b1, 3'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
